// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between two byte requesters, the arbiter and a UART transmitter.
// The master modport is the requester/transmitter side; the slave modport is the arbiter.
interface uart_tx_arbiter_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       tx_busy;
  logic       send_en;
  logic [7:0] send_data;
  logic       grant_id;
  logic       tx_timeout;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, tx_busy,
    input  req0_ready, req1_ready, send_en, send_data, grant_id, tx_timeout
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, tx_busy,
    output req0_ready, req1_ready, send_en, send_data, grant_id, tx_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter, one byte in flight at a time.
// Define UART_ARB_TIMEOUT_EN to abandon a byte when tx_busy never rises within BUSY_TIMEOUT.
module uart_tx_arbiter #(
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  uart_tx_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StWaitHi, StWaitLo} state_e;

  if (BUSY_TIMEOUT == 0) begin : g_bad_timeout
    $error("BUSY_TIMEOUT must be nonzero");
  end

  state_e     state_q, state_d;
  logic       send_en_q, send_en_d;
  logic [7:0] send_data_q, send_data_d;
  logic       grant_q, grant_d;
  logic       ptr_q, ptr_d;  // 1: requester 1 wins a tie
  logic       can_accept, sel1, ready0, ready1;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(BUSY_TIMEOUT + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
`endif

  assign can_accept = (state_q == StIdle) && !bus.tx_busy && !sys_rst;
  assign sel1       = bus.req1_valid && (!bus.req0_valid || ptr_q);
  assign ready0     = can_accept && bus.req0_valid && !sel1;
  assign ready1     = can_accept && sel1;

  always_comb begin
    state_d     = state_q;
    send_en_d   = 1'b0;
    send_data_d = send_data_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (ready0 || ready1) begin
          send_data_d = sel1 ? bus.req1_data : bus.req0_data;
          grant_d     = sel1;
          send_en_d   = 1'b1;
          ptr_d       = !sel1;
          state_d     = StWaitHi;
`ifdef UART_ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      StWaitHi: begin
        if (bus.tx_busy) begin
          state_d = StWaitLo;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (cnt_q == CntW'(BUSY_TIMEOUT - 1)) begin
          // Byte is dropped; the pointer already moved at acceptance.
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StWaitLo: begin
        if (!bus.tx_busy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      send_en_q   <= 1'b0;
      send_data_q <= 8'h00;
      grant_q     <= 1'b0;
      ptr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      send_en_q   <= send_en_d;
      send_data_q <= send_data_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.tx_timeout = timeout_q;
`else
  assign bus.tx_timeout = 1'b0;
`endif

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.send_en    = send_en_q;
  assign bus.send_data  = send_data_q;
  assign bus.grant_id   = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single/dual requesters, busy stall, mid-op reset,
// and the busy-timeout path (expectations follow whether UART_ARB_TIMEOUT_EN is defined).
module tb_uart_tx_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        man_busy;
  logic        model_en;
  logic        model_busy;
  int unsigned mt;
  int          errors = 0;
  int          checks = 0;

  always #5 sys_clk = ~sys_clk;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(.BUSY_TIMEOUT(16)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  // Transmitter model: busy from 2 cycles after send_en for 10 cycles.
  always @(posedge sys_clk) begin
    if (!model_en)                 mt <= 0;
    else if (bus.send_en)          mt <= 1;
    else if (mt != 0 && mt < 12)   mt <= mt + 1;
    else                           mt <= 0;
  end
  assign model_busy = (mt >= 2) && (mt <= 11);
  assign bus.tx_busy = model_en ? model_busy : man_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    man_busy = 1'b0;
    model_en = 1'b0;
    tick();
    tick();
    sys_rst = 1'b0;
  endtask

  // From WAIT_HI: busy high for n edges, then low for one edge, ending in IDLE.
  task automatic busy_cycle(input int n);
    man_busy = 1'b1;
    repeat (n) tick();
    man_busy = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] seen[$];
    logic       gids[$];
    logic [7:0] exp_data[4];
    int         to_at;
    int         to_cnt;

    // Reset: ready held low even with both requesters valid
    sys_rst = 1'b1;
    model_en = 1'b0;
    man_busy = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'h41;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 8'h99;
    tick();
    tick();
    check("rst_rdy0", bus.req0_ready, 0);
    check("rst_rdy1", bus.req1_ready, 0);
    check("rst_en", bus.send_en, 0);
    check("rst_data", bus.send_data, 8'h00);
    check("rst_gid", bus.grant_id, 0);
    check("rst_tmo", bus.tx_timeout, 0);

    // Single byte from req0
    bus.req1_valid = 1'b0;
    sys_rst = 1'b0;
    settle();
    check("b1_rdy0", bus.req0_ready, 1);
    check("b1_rdy1", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 1'b0;
    check("b1_en", bus.send_en, 1);
    check("b1_data", bus.send_data, 8'h41);
    check("b1_gid", bus.grant_id, 0);
    bus.req0_valid = 1'b1;
    settle();
    check("wh_rdy0", bus.req0_ready, 0);
    bus.req0_valid = 1'b0;
    tick();
    check("b1_en_1cyc", bus.send_en, 0);
    man_busy = 1'b1;
    repeat (10) tick();
    bus.req0_valid = 1'b1;
    settle();
    check("wl_rdy0_busy", bus.req0_ready, 0);
    man_busy = 1'b0;
    settle();
    check("wl_rdy0_free", bus.req0_ready, 0);
    tick();
    check("idle_rdy0", bus.req0_ready, 1);
    check("b1_hold", bus.send_data, 8'h41);
    bus.req0_valid = 1'b0;

    // Only req1 for three bytes, then tie goes back to req0
    do_reset();
    bus.req1_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      bus.req1_data = 8'(k);
      settle();
      check($sformatf("r1_rdy1_%0d", k), bus.req1_ready, 1);
      check($sformatf("r1_rdy0_%0d", k), bus.req0_ready, 0);
      tick();
      check($sformatf("r1_en_%0d", k), bus.send_en, 1);
      check($sformatf("r1_gid_%0d", k), bus.grant_id, 1);
      check($sformatf("r1_data_%0d", k), bus.send_data, 32'(k));
      busy_cycle(3);
    end
    bus.req0_valid = 1'b1;
    settle();
    check("r1_tie_rdy0", bus.req0_ready, 1);
    check("r1_tie_rdy1", bus.req1_ready, 0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // Busy in IDLE stalls; a dropped valid leaves the pointer alone
    do_reset();
    man_busy = 1'b1;
    bus.req1_valid = 1'b1;
    settle();
    check("stall_rdy1", bus.req1_ready, 0);
    tick();
    tick();
    check("stall_en", bus.send_en, 0);
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'h5A;
    settle();
    check("stall_rdy0", bus.req0_ready, 0);
    man_busy = 1'b0;
    settle();
    check("free_rdy0", bus.req0_ready, 1);
    bus.req1_valid = 1'b1;
    settle();
    check("ptr_keep_rdy0", bus.req0_ready, 1);
    check("ptr_keep_rdy1", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check("stall_xfer_en", bus.send_en, 1);
    check("stall_xfer_data", bus.send_data, 8'h5A);
    check("stall_xfer_gid", bus.grant_id, 0);

    // Reset in WAIT_LO abandons the byte and restores the pointer
    tick();
    man_busy = 1'b1;
    tick();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    man_busy = 1'b0;
    check("mrst_en", bus.send_en, 0);
    check("mrst_data", bus.send_data, 8'h00);
    check("mrst_gid", bus.grant_id, 0);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    settle();
    check("mrst_rdy0", bus.req0_ready, 1);
    check("mrst_rdy1", bus.req1_ready, 0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    check("mrst_noretry", bus.send_en, 0);

    // tx_busy never rises after send_en
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'h77;
    tick();
    bus.req0_valid = 1'b0;
    check("tmo_en", bus.send_en, 1);
    to_at = -1;
    to_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.tx_timeout === 1'b1) begin
        to_cnt++;
        if (to_at < 0) to_at = k;
      end
    end
`ifdef UART_ARB_TIMEOUT_EN
    check("tmo_count", to_cnt, 1);
    check("tmo_cycle", to_at, 16);
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'h78;
    settle();
    check("tmo_rdy0", bus.req0_ready, 1);
    tick();
    bus.req0_valid = 1'b0;
    check("tmo_next_en", bus.send_en, 1);
    check("tmo_next_data", bus.send_data, 8'h78);
`else
    check("tmo_count", to_cnt, 0);
    bus.req0_valid = 1'b1;
    settle();
    check("tmo_stuck_rdy0", bus.req0_ready, 0);
    bus.req0_valid = 1'b0;
`endif

    // Both valid continuously with the transmitter model: strict alternation
    do_reset();
    model_en = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'hA0;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 8'hB1;
    exp_data[0] = 8'hA0;
    exp_data[1] = 8'hB1;
    exp_data[2] = 8'hA0;
    exp_data[3] = 8'hB1;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (bus.send_en === 1'b1) begin
        seen.push_back(bus.send_data);
        gids.push_back(bus.grant_id);
      end
      if (seen.size() == 4) break;
    end
    check("rr_count", seen.size(), 4);
    for (int i = 0; i < seen.size() && i < 4; i++) begin
      check($sformatf("rr_data_%0d", i), seen[i], exp_data[i]);
      check($sformatf("rr_gid_%0d", i), gids[i], (i % 2));
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    model_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter BUSY_TIMEOUT, default 16, meaning cycles to wait for tx_busy to rise after send_en (used only with UART_ARB_TIMEOUT_EN).
REQ-002 The block SHALL have port sys_clk  input  1  single clock; all logic on its rising edge.
REQ-003 The block SHALL have port sys_rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port req0_valid  input  1  requester 0 has a byte.
REQ-005 The block SHALL have port req0_data  input  8  requester 0 byte.
REQ-006 The block SHALL have port req0_ready  output  1  requester 0 byte accepted this cycle.
REQ-007 The block SHALL have ports req1_valid, req1_data, req1_ready, identical to requester 0.
REQ-008 The block SHALL have port tx_busy  input  1  UART transmitter busy flag.
REQ-009 The block SHALL have port send_en  output  1  one-cycle transmit start pulse, registered.
REQ-010 The block SHALL have port send_data  output  8  byte to transmit, registered.
REQ-011 The block SHALL have port grant_id  output  1  requester of the most recently accepted byte, registered.
REQ-012 The block SHALL have port tx_timeout  output  1  one-cycle pulse on busy timeout, registered.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT_HI (waiting for tx_busy=1) and WAIT_LO (waiting for tx_busy=0).
REQ-014 reqN_ready SHALL be combinational: 1 only when state=IDLE, tx_busy=0, sys_rst=0, reqN_valid=1 and N is the arbitration winner.
REQ-015 Winner: the only valid requester; if both valid, the one holding the round-robin pointer.
REQ-016 A transfer SHALL occur on the edge where valid and ready are both 1; at that edge send_data<=reqN_data, grant_id<=N, send_en<=1, pointer<=other requester, state<=WAIT_HI.
REQ-017 send_en SHALL be 1 for exactly one cycle per transfer and cleared on the following edge.
REQ-018 send_data and grant_id SHALL hold until the next transfer.
REQ-019 WAIT_HI SHALL go to WAIT_LO on the first edge tx_busy=1; WAIT_LO SHALL go to IDLE on the first edge tx_busy=0.
REQ-020 At most one byte SHALL be in flight; no ready is given outside IDLE.
REQ-021 In IDLE with tx_busy=1 (foreign or stale activity), no transfer SHALL occur.
REQ-022 A valid that drops before ready SHALL cause no transfer and no pointer change.
REQ-023 The pointer SHALL change only on a transfer; a single requester may win back-to-back when the other is idle.
REQ-024 Minimum spacing between transfers SHALL be 3 cycles (IDLE->WAIT_HI->WAIT_LO->IDLE).

Reset
REQ-025 With sys_rst=1 at an edge: state<=IDLE, send_en<=0, send_data<=8'h00, grant_id<=0, tx_timeout<=0, pointer<=requester 0, timeout counter<=0.
REQ-026 While sys_rst=1, req0_ready and req1_ready SHALL be 0.
REQ-027 Reset mid-operation (any state) SHALL abandon the byte in flight with no retry.

Configuration
REQ-028 Macro UART_ARB_TIMEOUT_EN defined: a counter SHALL clear on entry to WAIT_HI and increment each WAIT_HI cycle with tx_busy=0; on reaching BUSY_TIMEOUT, tx_timeout SHALL pulse one cycle and state<=IDLE (byte dropped, pointer already advanced).
REQ-029 Macro UART_ARB_TIMEOUT_EN undefined: WAIT_HI SHALL wait indefinitely, no counter is built, tx_timeout SHALL be constant 0.

Verification
REQ-030 req0_valid=1, data 8'h41, tx_busy rises 2 cycles after send_en, held 10 cycles -> req0_ready 1 cycle, send_en 1 cycle, send_data=8'h41, grant_id=0, return to IDLE.
REQ-031 Both valid continuously (8'hA0 / 8'hB1), tx model busy 10 cycles per byte -> send_data alternates A0,B1,A0,B1 starting with req0 after reset.
REQ-032 Only req1 valid for 3 bytes 8'h01..8'h03 -> three consecutive grants to req1 (grant_id=1), no grant to req0.
REQ-033 tx_busy=1 in IDLE with req0_valid=1 -> req0_ready=0 until tx_busy=0, then transfer.
REQ-034 sys_rst pulsed in WAIT_LO -> next cycle IDLE, send_en=0, send_data=8'h00, pointer at req0.
REQ-035 With UART_ARB_TIMEOUT_EN, BUSY_TIMEOUT=16, tx_busy stuck 0 after send_en -> tx_timeout pulses 16 cycles after WAIT_HI entry, state IDLE, next byte accepted; without macro, block remains in WAIT_HI, tx_timeout=0.
